// File: rtl/uart_cmd_ctl.sv
// uart_cmd_ctl: byte-oriented command decoder between a UART and a small
// 16-bit-address / 8-bit-data memory bus.
//
//   'W' addr_hi addr_lo data  -> one memory write, reply ACK
//   'R' addr_hi addr_lo       -> one memory read, reply the read byte
//   anything else             -> reply NAK
//
// Ports
//   clock        in   single rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   rx_data[7:0] in   received byte, valid while rx_ready is high
//   rx_ready     in   one-cycle receive pulse
//   tx_data[7:0] out  reply byte, held from load until the reply completes
//   tx_we        out  one-cycle transmit strobe
//   tx_ready     in   transmitter idle / able to accept
//   mem_address  out  16-bit memory address
//   mem_out      out  write data to memory
//   mem_we       out  one-cycle memory write enable
//   mem_in       in   read data, valid one cycle after the address settles
//   busy         out  high whenever the controller is not idle
//
// State | meaning
// IDLE  | waiting for a command byte
// AHI   | waiting for address high byte
// ALO   | waiting for address low byte
// DAT   | waiting for write data byte
// MEMW  | memory write strobe, load ACK
// MEMR0 | address settling for the read
// MEMR1 | capture read data as the reply
// TXS   | wait for transmitter idle, then strobe tx_we
// TXB   | wait for transmitter to report busy
// TXD   | wait for transmitter to finish
module uart_cmd_ctl #(
  parameter int unsigned TIMEOUT = 2500000,
  parameter logic [7:0]  ACK     = 8'h2E,
  parameter logic [7:0]  NAK     = 8'h3F
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_we,
  input  logic        tx_ready,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_out,
  output logic        mem_we,
  input  logic [7:0]  mem_in,
  output logic        busy
);

  localparam logic [7:0]  CMD_W    = 8'h57;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    AHI   = 4'd1,
    ALO   = 4'd2,
    DAT   = 4'd3,
    MEMW  = 4'd4,
    MEMR0 = 4'd5,
    MEMR1 = 4'd6,
    TXS   = 4'd7,
    TXB   = 4'd8,
    TXD   = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] addr_q,  addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  txd_q,   txd_d;
  logic [23:0] tmr_q,   tmr_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    // The inter-byte timer only runs while collecting command bytes; it
    // sits at zero everywhere else so each field starts a fresh window.
    tmr_d   = '0;
    mem_we  = 1'b0;
    tx_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_ready) begin
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            is_wr_d = (rx_data == CMD_W);
            state_d = AHI;
          end else begin
            txd_d   = NAK;
            state_d = TXS;
          end
        end
      end

      // A byte arriving on the terminal-count cycle wins over the timeout.
      AHI: begin
        if (rx_ready) begin
          addr_d[15:8] = rx_data;
          state_d      = ALO;
        end else if (tmr_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 24'd1;
        end
      end

      ALO: begin
        if (rx_ready) begin
          addr_d[7:0] = rx_data;
          state_d     = is_wr_q ? DAT : MEMR0;
        end else if (tmr_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 24'd1;
        end
      end

      DAT: begin
        if (rx_ready) begin
          wdata_d = rx_data;
          state_d = MEMW;
        end else if (tmr_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 24'd1;
        end
      end

      MEMW: begin
        mem_we  = 1'b1;
        txd_d   = ACK;
        state_d = TXS;
      end

      // Address has been stable since ALO; memory returns data next cycle.
      MEMR0: state_d = MEMR1;

      MEMR1: begin
        txd_d   = mem_in;
        state_d = TXS;
      end

      TXS: begin
        if (tx_ready) begin
          tx_we   = 1'b1;
          state_d = TXB;
        end
      end

      TXB: if (!tx_ready) state_d = TXD;

      TXD: if (tx_ready) state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign tx_data     = txd_q;
  assign mem_address = addr_q;
  assign mem_out     = wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctl.sv
// tb_uart_cmd_ctl: directed stimulus for uart_cmd_ctl with a scoreboard.
// Stimulus pushes the expected reply bytes and memory writes into queues;
// a monitor pops and compares whenever tx_we or mem_we fires.
`timescale 1ns/1ps
module tb_uart_cmd_ctl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_ready;
  logic [15:0] mem_address;
  logic [7:0]  mem_out;
  logic        mem_we;
  logic [7:0]  mem_in;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int tx_pulses = 0;
  int mem_pulses = 0;
  bit hold_tx = 1'b0;

  logic [7:0]  exp_tx_q[$];
  logic [23:0] exp_mem_q[$];
  logic [7:0]  mem [0:65535];

  always #5 clock = ~clock;

  uart_cmd_ctl #(.TIMEOUT(100), .ACK(8'h2E), .NAK(8'h3F)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_we       (tx_we),
    .tx_ready    (tx_ready),
    .mem_address (mem_address),
    .mem_out     (mem_out),
    .mem_we      (mem_we),
    .mem_in      (mem_in),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: registered read, write on mem_we.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFF] = 8'h3C;
    mem[16'h0001] = 8'h77;
    mem[16'h0002] = 8'h5A;
    mem[16'h0003] = 8'hC7;
    mem_in = 8'h00;
    forever begin
      @(posedge clock);
      mem_in <= mem[mem_address];
      if (mem_we) mem[mem_address] <= mem_out;
    end
  end

  // Transmitter model: busy for four cycles after each tx_we.
  initial begin
    int  cnt;
    bit  pend;
    cnt = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clock);
      pend = tx_we;
      @(posedge clock);
      #1;
      if (pend) cnt = 4;
      else if (cnt > 0) cnt--;
      tx_ready = !hold_tx && (cnt == 0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (tx_we && mem_we) chk("strobe_overlap", 32'(tx_we & mem_we), 32'd0);
        if (mem_we) begin
          mem_pulses++;
          if (exp_mem_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mem_unexpected: got mem_we addr=%h data=%h, required none", mem_address, mem_out);
          end else begin
            chk("mem_write", {8'h00, mem_address, mem_out}, {8'h00, exp_mem_q.pop_front()});
          end
        end
        if (tx_we) begin
          tx_pulses++;
          if (exp_tx_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_unexpected: got tx_we data=%h, required none", tx_data);
          end else begin
            chk("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clock);
    #1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (!busy) break;
    end
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_txq"}, 32'(exp_tx_q.size()), 32'd0);
    chk({name, "_memq"}, 32'(exp_mem_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_strobes"}, {30'd0, tx_we, mem_we}, 32'd0);
    chk({name, "_tx_data"}, {24'h0, tx_data}, 32'd0);
    chk({name, "_mem_out"}, {24'h0, mem_out}, 32'd0);
    chk({name, "_mem_address"}, {16'h0, mem_address}, 32'd0);
  endtask

  initial begin
    int snap_tx, snap_mem;
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);

    // Write 1234 <- A5
    exp_mem_q.push_back({16'h1234, 8'hA5});
    exp_tx_q.push_back(8'h2E);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    wait_idle("write");

    // Read FFFF -> 3C, no memory write
    snap_mem = mem_pulses;
    exp_tx_q.push_back(8'h3C);
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF);
    wait_idle("read_ffff");
    chk("read_ffff_addr", {16'h0, mem_address}, 32'h0000FFFF);
    chk("read_ffff_no_memwe", 32'(mem_pulses), 32'(snap_mem));

    // Unknown command, then a normal read
    exp_tx_q.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle("nak");
    exp_tx_q.push_back(8'hC7);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h03);
    wait_idle("read_after_nak");

    // Timeout after 57,12: still busy at TIMEOUT-1, idle after TIMEOUT cycles
    snap_tx  = tx_pulses;
    snap_mem = mem_pulses;
    send_byte(8'h57); send_byte(8'h12);
    repeat (99) @(posedge clock);
    @(negedge clock);
    chk("timeout_busy_before", 32'(busy), 32'd1);
    @(negedge clock);
    chk("timeout_idle", 32'(busy), 32'd0);
    chk("timeout_no_tx", 32'(tx_pulses), 32'(snap_tx));
    chk("timeout_no_mem", 32'(mem_pulses), 32'(snap_mem));
    exp_tx_q.push_back(8'h77);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    wait_idle("read_after_timeout");

    // Byte arriving on the terminal-count cycle is accepted
    exp_mem_q.push_back({16'h5678, 8'h9C});
    exp_tx_q.push_back(8'h2E);
    send_byte(8'h57); send_byte(8'h56);
    repeat (98) @(posedge clock);
    send_byte(8'h78); send_byte(8'h9C);
    wait_idle("tmo_priority");

    // Transmit backpressure with ignored rx bytes
    hold_tx = 1'b1;
    repeat (2) @(posedge clock);
    snap_tx = tx_pulses;
    exp_tx_q.push_back(8'h5A);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
    repeat (100) @(posedge clock);
    send_byte(8'h57);
    repeat (200) @(posedge clock);
    send_byte(8'h52);
    repeat (200) @(posedge clock);
    @(negedge clock);
    chk("bp_no_tx", 32'(tx_pulses), 32'(snap_tx));
    chk("bp_busy", 32'(busy), 32'd1);
    hold_tx = 1'b0;
    wait_idle("backpressure");
    chk("bp_one_tx", 32'(tx_pulses), 32'(snap_tx + 1));

    // Reset while in DAT
    snap_tx  = tx_pulses;
    snap_mem = mem_pulses;
    send_byte(8'h57); send_byte(8'hAB); send_byte(8'hCD);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    chk("mid_reset_no_tx", 32'(tx_pulses), 32'(snap_tx));
    chk("mid_reset_no_mem", 32'(mem_pulses), 32'(snap_mem));
    exp_mem_q.push_back({16'h0000, 8'h11});
    exp_tx_q.push_back(8'h2E);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h11);
    wait_idle("write_after_reset");
    exp_tx_q.push_back(8'h11);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    wait_idle("readback_0000");

    repeat (5) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
